// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch buffer.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN       = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8020_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
    logic                  filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order circular prefetch buffer: entries are allocated at issue, filled by
// memory responses in request order, and popped by decode.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    alloc,
  input  logic [XLEN-1:0]         alloc_pc,
  input  logic                    fill,
  input  logic [31:0]             fill_inst,
  input  logic                    pop,
  output logic                    head_filled,
  output logic [XLEN-1:0]         head_pc,
  output logic [31:0]             head_inst,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  pending
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  entries_q [DEPTH];
  fetch_entry_t  entries_d [DEPTH];
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] pend_q, pend_d;

  // Popped entries drop their filled bit so a wrapped head never sees a stale one.
  always_comb begin
    entries_d   = entries_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q + CW'(alloc) - CW'(pop);
    pend_d      = pend_q + CW'(alloc) - CW'(fill);
    if (pop) begin
      entries_d[head_ptr_q].filled = 1'b0;
      head_ptr_d = head_ptr_q + PW'(1);
    end
    if (alloc) begin
      entries_d[alloc_ptr_q] = '{pc: FETCH_XLEN'(alloc_pc), inst: INST_NOP, filled: 1'b0};
      alloc_ptr_d = alloc_ptr_q + PW'(1);
    end
    if (fill) begin
      entries_d[fill_ptr_q].inst   = fill_inst;
      entries_d[fill_ptr_q].filled = 1'b1;
      fill_ptr_d = fill_ptr_q + PW'(1);
    end
    if (clear) begin
      foreach (entries_d[i]) entries_d[i].filled = 1'b0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      pend_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q   <= '{default: '0};
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pend_q      <= '0;
    end else begin
      entries_q   <= entries_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
    end
  end

  assign head_filled = entries_q[head_ptr_q].filled;
  assign head_pc     = XLEN'(entries_q[head_ptr_q].pc);
  assign head_inst   = entries_q[head_ptr_q].inst;
  assign count       = count_q;
  assign pending     = pend_q;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: PC generation, request issue, redirect flush and
// stale-response dropping. FETCH_PERF_CNT_EN adds bubble/drop perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned      DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [XLEN-1:0]         imem_req_addr,
  input  logic                    imem_resp_valid,
  input  logic [31:0]             imem_resp_inst,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    stall,
  output logic                    id_valid,
  input  logic                    id_ready,
  output logic [XLEN-1:0]         id_pc,
  output logic [31:0]             id_inst,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]             perf_bubbles,
  output logic [31:0]             perf_drops,
`endif
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = CW + 8;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic            accept, resp_take, resp_drop, pop, head_filled;
  logic [CW-1:0]   count, pending;

  assign imem_req_valid = !rst && !redirect_valid && !stall && (count < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign resp_take      = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign resp_drop      = imem_resp_valid && !resp_take;
  assign id_valid       = head_filled && !redirect_valid;
  assign pop            = id_valid && id_ready && !stall;
  assign fifo_count     = count;

  fetch_buffer #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .clear       (redirect_valid),
    .alloc       (accept),
    .alloc_pc    (fetch_pc_q),
    .fill        (resp_take),
    .fill_inst   (imem_resp_inst),
    .pop         (pop),
    .head_filled (head_filled),
    .head_pc     (id_pc),
    .head_inst   (id_inst),
    .count       (count),
    .pending     (pending)
  );

  // Requests still in flight at a redirect are owed to memory; a response in the
  // redirect cycle itself already settles one of them.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      drop_cnt_d = drop_cnt_q + DW'(pending) - DW'(imem_resp_valid);
    end else begin
      if (accept)    fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_drop) drop_cnt_d = drop_cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_drops_q, perf_drops_d;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_drops_d   = perf_drops_q;
    if (id_ready && !stall && !id_valid && (perf_bubbles_q != '1))
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    if (resp_drop && (perf_drops_q != '1))
      perf_drops_d = perf_drops_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles_q <= '0;
      perf_drops_q   <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_drops_q   <= perf_drops_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_drops   = perf_drops_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle instruction fetch path of the pipelined RV64 CPU.
- Decouples PC generation from the IF/ID register using a multi-entry, in-order prefetch buffer and a valid/ready instruction-memory interface. Memory latency is variable and up to DEPTH requests may be outstanding.
- Handles jump/branch/trap redirects by flushing the buffer and discarding stale in-flight responses.
- Sits between PC-next logic (supplies redirect) and the decode stage (consumes pc/inst).

Parameters:
- XLEN, 64, address/PC width.
- RESET_PC, 64'h80200000, PC after reset (truncated to XLEN).
- DEPTH, 4, buffer entries and maximum outstanding requests; power of 2, >= 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (current fetch PC).
- imem_resp_valid  in  1  response valid; responses return in request order, always accepted.
- imem_resp_inst  in  32  returned instruction.
- redirect_valid  in  1  flush and restart fetch (jump/branch taken/trap/sret).
- redirect_pc  in  XLEN  new fetch PC.
- stall  in  1  global stall; freezes issue and dequeue.
- id_valid  out  1  head entry holds an instruction.
- id_ready  in  1  decode consumes head.
- id_pc  out  XLEN  PC of head entry.
- id_inst  out  32  instruction of head entry.
- fifo_count  out  $clog2(DEPTH)+1  allocated entries, filled or pending.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: fetch_pc=RESET_PC; all pointers 0; fifo_count=0; drop_cnt=0; imem_req_valid=0; id_valid=0; id_pc=0; id_inst=0.
- Buffer:
  - Circular, DEPTH entries of {pc, inst, filled}, with three pointers: alloc_ptr, fill_ptr, head_ptr.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - fifo_count is tracked separately so full/empty are unambiguous.
- Issue:
  - imem_req_valid = !redirect_valid && !stall && fifo_count<DEPTH.
  - On accept (valid && ready): the entry at alloc_ptr gets pc=fetch_pc, filled=0; alloc_ptr++; fetch_pc += 4.
- Response (drop_cnt==0, no redirect):
  - The entry at fill_ptr gets inst and filled=1; fill_ptr++.
  - A response arriving with no pending entry is a protocol error; the bench asserts this never happens.
- Output:
  - id_valid = head entry filled && !redirect_valid; id_pc/id_inst come from the head entry.
  - Pop when id_valid && id_ready && !stall: head_ptr++.
  - Response-to-id_valid latency is 1 cycle; there is no combinational resp->id bypass.
- Simultaneous events:
  - Issue, fill and pop may all occur in the same cycle.
  - fifo_count += accept - pop.
  - At fifo_count==DEPTH with a pop in the same cycle, no issue occurs that cycle (issue is gated on the registered count).
- Redirect (highest priority):
  - Next cycle: all pointers=0, fifo_count=0, fetch_pc=redirect_pc.
  - drop_cnt <= drop_cnt + pending_unfilled - (imem_resp_valid ? 1 : 0), where pending_unfilled = alloc_ptr - fill_ptr (mod, derived from counts).
  - A response in the redirect cycle is discarded. No request and no pop occur in that cycle.
- Drop: while drop_cnt>0, each imem_resp_valid decrements drop_cnt and is discarded. New requests may issue during draining; their responses are accepted only after drop_cnt reaches 0.
- Stall:
  - No issue and no pop.
  - Responses are still filled or dropped.
  - id_valid/id_pc/id_inst remain stable.
- Redirect while stall=1 is still applied.
- Reset mid-operation clears everything. Responses to pre-reset requests are the memory's responsibility (the memory is reset on the same rst).
- PC arithmetic: XLEN-bit modulo wrap; low two bits are passed through unchecked.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_bubbles (out, 32) and perf_drops (out, 32).
  - perf_bubbles increments each cycle where id_ready && !stall && !id_valid.
  - perf_drops increments per discarded response.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - RESET_PC default;
  - INST_NOP = 32'h00000013;
  - typedef fetch_entry_t {pc, inst, filled}, parametrised via XLEN localparam.
- Sub-module fetch_buffer: circular buffer with alloc/fill/pop/clear ports and count output. fetch_unit keeps fetch_pc, drop_cnt, issue gating and perf counters.

Test Plan:
1. Reset, memory always ready, 1-cycle response latency, id_ready=1 -> requests at 80200000, 80200004, ...; first id_valid 2 cycles after rst release; id_pc=80200000 with matching inst; then one instruction per cycle.
2. id_ready=0, memory ready -> exactly 4 requests issued; fifo_count=4; imem_req_valid=0 until a pop; after a single pop, exactly one more request, to 80200010.
3. Memory latency 3, 3 requests outstanding, redirect_pc=80201000 -> next 3 responses discarded (drop_cnt 3->0); first delivered id_pc=80201000.
4. Redirect in the same cycle as imem_resp_valid and a would-be pop -> response discarded, no pop, fifo_count=0 next cycle, id_valid=0 that cycle.
5. stall=1 for 5 cycles with responses arriving -> no new requests, head stable, entries fill; on release, in-order delivery resumes with no loss.
6. FETCH_PERF_CNT_EN defined, scenario 3 -> perf_drops=3; 5 empty consumer cycles -> perf_bubbles=5.
